// File: rtl/fir_sp_packer.sv
// Serial-to-parallel input stage for the 3-parallel FIR: packs three consecutive
// samples into one parallel word, with zero-padded flush of a partial group.
module fir_sp_packer #(
    parameter int              NB      = 8,
    parameter logic [NB-1:0]   PAD_VAL = {NB{1'b0}}
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [NB-1:0] DIN,
    input  logic          VIN,
    input  logic          FLUSH,
    output logic [NB-1:0] DOUT0,
    output logic [NB-1:0] DOUT1,
    output logic [NB-1:0] DOUT2,
    output logic          VOUT,
    output logic [1:0]    NPAD
);

    localparam logic [1:0] P0 = 2'd0;
    localparam logic [1:0] P1 = 2'd1;
    localparam logic [1:0] P2 = 2'd2;

    logic [1:0]    phase_r;
    logic [NB-1:0] h0_r;
    logic [NB-1:0] h1_r;
    logic [NB-1:0] dout0_r;
    logic [NB-1:0] dout1_r;
    logic [NB-1:0] dout2_r;
    logic          vout_r;
    logic [1:0]    npad_r;

    logic [1:0]    phase_a_s;
    logic [1:0]    phase_s;
    logic [NB-1:0] h0_s;
    logic [NB-1:0] h1_s;
    logic [NB-1:0] dout0_s;
    logic [NB-1:0] dout1_s;
    logic [NB-1:0] dout2_s;
    logic          emit_s;
    logic [1:0]    npad_s;

    // Next-state: accept the sample first, then let FLUSH act on the resulting phase.
    always_comb begin
        phase_a_s = phase_r;
        h0_s      = h0_r;
        h1_s      = h1_r;
        dout0_s   = dout0_r;
        dout1_s   = dout1_r;
        dout2_s   = dout2_r;
        npad_s    = npad_r;
        emit_s    = 1'b0;

        if (VIN) begin
            case (phase_r)
                P0: begin
                    h0_s      = DIN;
                    phase_a_s = P1;
                end
                P1: begin
                    h1_s      = DIN;
                    phase_a_s = P2;
                end
                P2: begin
                    dout0_s   = h0_r;
                    dout1_s   = h1_r;
                    dout2_s   = DIN;
                    npad_s    = 2'd0;
                    emit_s    = 1'b1;
                    phase_a_s = P0;
                end
                default: begin
                    phase_a_s = P0;
                end
            endcase
        end else begin
            phase_a_s = phase_r;
        end

        phase_s = phase_a_s;
        // A completed group already leaves the phase at P0, so FLUSH only matters in P1/P2.
        if (FLUSH) begin
            case (phase_a_s)
                P1: begin
                    dout0_s = h0_s;
                    dout1_s = PAD_VAL;
                    dout2_s = PAD_VAL;
                    npad_s  = 2'd2;
                    emit_s  = 1'b1;
                    phase_s = P0;
                end
                P2: begin
                    dout0_s = h0_s;
                    dout1_s = h1_s;
                    dout2_s = PAD_VAL;
                    npad_s  = 2'd1;
                    emit_s  = 1'b1;
                    phase_s = P0;
                end
                default: begin
                    phase_s = phase_a_s;
                end
            endcase
        end else begin
            phase_s = phase_a_s;
        end
    end

    // State and output registers; reset drops any partial group.
    always_ff @(posedge CLK) begin
        if (RST) begin
            phase_r <= P0;
            h0_r    <= {NB{1'b0}};
            h1_r    <= {NB{1'b0}};
            dout0_r <= {NB{1'b0}};
            dout1_r <= {NB{1'b0}};
            dout2_r <= {NB{1'b0}};
            vout_r  <= 1'b0;
            npad_r  <= 2'd0;
        end else begin
            phase_r <= phase_s;
            h0_r    <= h0_s;
            h1_r    <= h1_s;
            dout0_r <= dout0_s;
            dout1_r <= dout1_s;
            dout2_r <= dout2_s;
            vout_r  <= emit_s;
            npad_r  <= npad_s;
        end
    end

    assign DOUT0 = dout0_r;
    assign DOUT1 = dout1_r;
    assign DOUT2 = dout2_r;
    assign VOUT  = vout_r;
    assign NPAD  = npad_r;

endmodule

// File: tb/tb_fir_sp_packer.sv
// Self-checking bench for fir_sp_packer: directed scenarios plus a random stream
// reconstructed from the parallel words and compared against the accepted samples.
module tb_fir_sp_packer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din = 8'd0;
    logic       vin = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] dout0, dout1, dout2;
    logic       vout;
    logic [1:0] npad;

    int total = 0;
    int bad = 0;

    fir_sp_packer #(.NB(8), .PAD_VAL(8'h00)) dut (
        .CLK(clk), .RST(rst), .DIN(din), .VIN(vin), .FLUSH(flush),
        .DOUT0(dout0), .DOUT1(dout1), .DOUT2(dout2), .VOUT(vout), .NPAD(npad)
    );

    always #5 clk = ~clk;

    // Present one cycle of inputs, then observe 1 time unit after the edge.
    task automatic cyc(input logic v, input logic [7:0] d, input logic f);
        vin = v; din = d; flush = f;
        @(posedge clk);
        #1;
        vin = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; cyc(1'b0, 8'd0, 1'b0); rst = 1'b0;
        total++; if (vout !== 1'b0) begin bad++; $display("FAIL reset_vout got=%0b want=0", vout); end
        total++; if ({dout0, dout1, dout2, npad} !== 26'd0) begin bad++;
            $display("FAIL reset_outs got=%h,%h,%h npad=%0d want=0,0,0 npad=0", dout0, dout1, dout2, npad); end
    endtask

    task automatic test_back_to_back;
        for (int i = 1; i <= 6; i++) begin
            cyc(1'b1, 8'(i), 1'b0);
            if (i % 3 == 0) begin
                total++; if (vout !== 1'b1) begin bad++; $display("FAIL b2b_vout i=%0d got=%0b want=1", i, vout); end
                total++; if ({dout0, dout1, dout2, npad} !== {8'(i-2), 8'(i-1), 8'(i), 2'd0}) begin bad++;
                    $display("FAIL b2b_word got=%0d,%0d,%0d npad=%0d want=%0d,%0d,%0d npad=0", dout0, dout1, dout2, npad, i-2, i-1, i); end
            end else begin
                total++; if (vout !== 1'b0) begin bad++; $display("FAIL b2b_idle i=%0d got=%0b want=0", i, vout); end
            end
        end
    endtask

    task automatic test_gaps;
        int gaps[3] = '{0, 2, 5};
        for (int s = 0; s < 3; s++) begin
            for (int g = 0; g < gaps[s]; g++) begin
                cyc(1'b0, 8'hAA, 1'b0);
                total++; if (vout !== 1'b0) begin bad++; $display("FAIL gap_idle got=%0b want=0", vout); end
            end
            cyc(1'b1, 8'(10 + s), 1'b0);
            if (s < 2) begin
                total++; if (vout !== 1'b0) begin bad++; $display("FAIL gap_early s=%0d got=%0b want=0", s, vout); end
            end else begin
                total++; if ({vout, dout0, dout1, dout2, npad} !== {1'b1, 8'd10, 8'd11, 8'd12, 2'd0}) begin bad++;
                    $display("FAIL gap_word got=v%0b %0d,%0d,%0d npad=%0d want=v1 10,11,12 npad=0", vout, dout0, dout1, dout2, npad); end
            end
        end
        cyc(1'b0, 8'd0, 1'b0);
        total++; if ({vout, dout0, dout1, dout2} !== {1'b0, 8'd10, 8'd11, 8'd12}) begin bad++;
            $display("FAIL gap_hold got=v%0b %0d,%0d,%0d want=v0 10,11,12", vout, dout0, dout1, dout2); end
    endtask

    task automatic test_flush;
        cyc(1'b1, 8'd7, 1'b0); cyc(1'b1, 8'd8, 1'b0);
        total++; if (vout !== 1'b0) begin bad++; $display("FAIL flush_pre got=%0b want=0", vout); end
        cyc(1'b0, 8'd0, 1'b1);
        total++; if ({vout, dout0, dout1, dout2, npad} !== {1'b1, 8'd7, 8'd8, 8'd0, 2'd1}) begin bad++;
            $display("FAIL flush_p2 got=v%0b %0d,%0d,%0d npad=%0d want=v1 7,8,0 npad=1", vout, dout0, dout1, dout2, npad); end
        cyc(1'b1, 8'd9, 1'b0); cyc(1'b0, 8'd0, 1'b1);
        total++; if ({vout, dout0, dout1, dout2, npad} !== {1'b1, 8'd9, 8'd0, 8'd0, 2'd2}) begin bad++;
            $display("FAIL flush_p1 got=v%0b %0d,%0d,%0d npad=%0d want=v1 9,0,0 npad=2", vout, dout0, dout1, dout2, npad); end
        cyc(1'b0, 8'd0, 1'b1);
        total++; if ({vout, npad} !== {1'b0, 2'd2}) begin bad++;
            $display("FAIL flush_p0 got=v%0b npad=%0d want=v0 npad=2", vout, npad); end
    endtask

    task automatic test_vin_flush;
        cyc(1'b1, 8'hFB, 1'b1);
        total++; if ({vout, dout0, dout1, dout2, npad} !== {1'b1, 8'hFB, 8'h00, 8'h00, 2'd2}) begin bad++;
            $display("FAIL vf_p0 got=v%0b %h,%h,%h npad=%0d want=v1 fb,00,00 npad=2", vout, dout0, dout1, dout2, npad); end
        cyc(1'b1, 8'd3, 1'b0); cyc(1'b1, 8'd4, 1'b1);
        total++; if ({vout, dout0, dout1, dout2, npad} !== {1'b1, 8'd3, 8'd4, 8'd0, 2'd1}) begin bad++;
            $display("FAIL vf_p1 got=v%0b %0d,%0d,%0d npad=%0d want=v1 3,4,0 npad=1", vout, dout0, dout1, dout2, npad); end
        cyc(1'b1, 8'd1, 1'b0); cyc(1'b1, 8'd2, 1'b0); cyc(1'b1, 8'd3, 1'b1);
        total++; if ({vout, dout0, dout1, dout2, npad} !== {1'b1, 8'd1, 8'd2, 8'd3, 2'd0}) begin bad++;
            $display("FAIL vf_p2 got=v%0b %0d,%0d,%0d npad=%0d want=v1 1,2,3 npad=0", vout, dout0, dout1, dout2, npad); end
        cyc(1'b0, 8'd0, 1'b0);
        total++; if (vout !== 1'b0) begin bad++; $display("FAIL vf_single got=%0b want=0", vout); end
    endtask

    task automatic test_reset_mid;
        cyc(1'b1, 8'd20, 1'b0); cyc(1'b1, 8'd21, 1'b0);
        rst = 1'b1; cyc(1'b0, 8'd0, 1'b0); rst = 1'b0;
        total++; if ({vout, dout0, dout1, dout2, npad} !== 27'd0) begin bad++;
            $display("FAIL rstmid_zero got=v%0b %0d,%0d,%0d npad=%0d want=all 0", vout, dout0, dout1, dout2, npad); end
        cyc(1'b1, 8'd30, 1'b0);
        total++; if (vout !== 1'b0) begin bad++; $display("FAIL rstmid_s30 got=%0b want=0", vout); end
        cyc(1'b1, 8'd31, 1'b0);
        total++; if (vout !== 1'b0) begin bad++; $display("FAIL rstmid_s31 got=%0b want=0", vout); end
        cyc(1'b1, 8'd32, 1'b0);
        total++; if ({vout, dout0, dout1, dout2, npad} !== {1'b1, 8'd30, 8'd31, 8'd32, 2'd0}) begin bad++;
            $display("FAIL rstmid_word got=v%0b %0d,%0d,%0d npad=%0d want=v1 30,31,32 npad=0", vout, dout0, dout1, dout2, npad); end
    endtask

    // Reference: count samples since last word; a word is due at 3 samples or on FLUSH with a partial group.
    task automatic test_random_stream;
        logic [7:0] in_q[$];
        logic [7:0] out_q[$];
        int pend = 0;
        int exp_np;
        logic exp_v, v, f, last;
        logic [7:0] d;
        rst = 1'b1; cyc(1'b0, 8'd0, 1'b0); rst = 1'b0;
        last = 1'b0;
        while (!last) begin
            if (in_q.size() >= 300) begin
                v = 1'b0; f = 1'b1; last = 1'b1;
            end else begin
                v = ($urandom_range(0, 99) < 30);
                f = ($urandom_range(0, 99) < 4);
            end
            d = 8'($urandom);
            if (v) begin in_q.push_back(d); pend++; end
            exp_v = 1'b0; exp_np = 0;
            if (pend == 3 || (f && pend > 0)) begin
                exp_v = 1'b1; exp_np = 3 - pend; pend = 0;
            end
            cyc(v, d, f);
            total++; if (vout !== exp_v) begin bad++; $display("FAIL rnd_vout n=%0d got=%0b want=%0b", in_q.size(), vout, exp_v); end
            if (vout && exp_v) begin
                total++; if (npad !== 2'(exp_np)) begin bad++; $display("FAIL rnd_npad got=%0d want=%0d", npad, exp_np); end
                out_q.push_back(dout0);
                if (exp_np < 2) out_q.push_back(dout1);
                else begin total++; if (dout1 !== 8'h00) begin bad++; $display("FAIL rnd_pad1 got=%h want=00", dout1); end end
                if (exp_np < 1) out_q.push_back(dout2);
                else begin total++; if (dout2 !== 8'h00) begin bad++; $display("FAIL rnd_pad2 got=%h want=00", dout2); end end
            end
        end
        total++; if (out_q.size() != in_q.size()) begin bad++;
            $display("FAIL rnd_len got=%0d want=%0d", out_q.size(), in_q.size()); end
        for (int i = 0; i < in_q.size() && i < out_q.size(); i++) begin
            total++; if (out_q[i] !== in_q[i]) begin bad++;
                $display("FAIL rnd_data idx=%0d got=%h want=%h", i, out_q[i], in_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_flush();
        test_vin_flush();
        test_reset_mid();
        test_random_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
